// File: rtl/prienc83_if.sv
// prienc83_if: request/handshake bundle for prienc83_seq (req, ready, ovf_clr in; code, valid, pending, pend_cnt, overflow out)
interface prienc83_if;
  logic [7:0] req;
  logic       ready;
  logic       ovf_clr;
  logic [2:0] code;
  logic       valid;
  logic [7:0] pending;
  logic [3:0] pend_cnt;
  logic       overflow;
  modport master (output req, ready, ovf_clr, input code, valid, pending, pend_cnt, overflow);
  modport slave (input req, ready, ovf_clr, output code, valid, pending, pend_cnt, overflow);
endinterface

// File: rtl/prienc83_seq.sv
// prienc83_seq: sticky 8-to-3 priority encoder presenting one pending request per valid/ready accept (ports: clk, rst async high, bus = req/ready/ovf_clr in, code/valid/pending/pend_cnt/overflow out)
module prienc83_seq #(
  parameter bit HIGH_FIRST  = 1'b1,
  parameter bit EDGE_DETECT = 1'b1
) (
  input logic       clk,
  input logic       rst,
  prienc83_if.slave bus
);
  typedef enum logic {IDLE, PRESENT} state_t;
  state_t     state, state_n;
  logic [7:0] req_d, pending, cap, clr, pend_n;
  logic [2:0] code, code_n;
  logic [3:0] cnt;
  logic       ovf, ovf_set, upd;
  function automatic logic [2:0] prio(input logic [7:0] v);
    prio = '0;
    for (int i = 0; i < 8; i++) begin
      if (HIGH_FIRST && v[i]) prio = 3'(i);
      if (!HIGH_FIRST && v[7-i]) prio = 3'(7 - i);
    end
  endfunction
  function automatic logic [3:0] popcnt(input logic [7:0] v);
    popcnt = '0;
    for (int i = 0; i < 8; i++) popcnt = popcnt + {3'b0, v[i]};
  endfunction
  always_comb begin
    cap     = EDGE_DETECT ? (bus.req & ~req_d) : bus.req;
    clr     = (state == PRESENT && bus.ready) ? (8'b1 << code) : 8'b0;
    pend_n  = (pending & ~clr) | cap;
    ovf_set = |(cap & pending & ~clr);
    upd     = (state == IDLE) || bus.ready;
    state_n = upd ? ((|pend_n) ? PRESENT : IDLE) : state;
    code_n  = (upd && |pend_n) ? prio(pend_n) : code;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      code    <= '0;
      req_d   <= '0;
      pending <= '0;
      cnt     <= '0;
      ovf     <= 1'b0;
    end else begin
      state   <= state_n;
      code    <= code_n;
      req_d   <= bus.req;
      pending <= pend_n;
      cnt     <= popcnt(pend_n);
      ovf     <= ovf_set | (ovf & ~bus.ovf_clr);
    end
  end
  assign bus.code     = code;
  assign bus.valid    = (state == PRESENT);
  assign bus.pending  = pending;
  assign bus.pend_cnt = cnt;
  assign bus.overflow = ovf;
endmodule
